bullet_pool: RTL and testbench

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pool.sv | 143 ++++++++++++++
 tb/tb_bullet_pool.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Pool of N_BULLETS upward-moving bullets with fire cooldown and a pixel overlay.
// Define BULLET_AUTOFIRE_EN to auto-repeat shots while fire is held high.

module bullet_slot #(
    parameter int         BULLET_LEN = 16,
    parameter int         BULLET_W   = 1,
    parameter logic [9:0] SPAWN_Y    = 10'd464
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alloc,
    input  logic       clr,
    input  logic       tick,
    input  logic [9:0] loadX,
    input  logic [9:0] horCnt,
    input  logic [9:0] verCnt,
    output logic       active,
    output logic       hit
);
    logic [9:0]  posX, posY;
    logic [10:0] yTop, yBot, xLo, xHi, h, v;

    // alloc only ever targets an inactive slot, so it cannot collide with a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            posX   <= '0;
            posY   <= '0;
        end else if (alloc) begin
            active <= 1'b1;
            posX   <= loadX;
            posY   <= SPAWN_Y;
        end else if (clr || (tick && active && posY == 10'd0)) begin
            active <= 1'b0;
            posX   <= '0;
            posY   <= '0;
        end else if (tick && active) begin
            posY <= posY - 10'd1;
        end
    end

    // 11-bit bounds so a bullet near the bottom edge never wraps
    assign yTop = {1'b0, posY};
    assign yBot = yTop + 11'(BULLET_LEN - 1);
    assign xLo  = {1'b0, posX} + 11'd1;
    assign xHi  = {1'b0, posX} + 11'(BULLET_W);
    assign h    = {1'b0, horCnt};
    assign v    = {1'b0, verCnt};
    assign hit  = active && (v >= yTop) && (v <= yBot) && (h >= xLo) && (h <= xHi);
endmodule

module bullet_pool #(
    parameter int         N_BULLETS  = 4,
    parameter int         BULLET_LEN = 16,
    parameter int         BULLET_W   = 1,
    parameter int         STEP_DIV   = 500000,
    parameter int         FIRE_GAP   = 40,
    parameter logic [9:0] SPAWN_Y    = 10'd464
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fire,
    input  logic                 collision,
    input  logic [2:0]           collIdx,
    input  logic [9:0]           playerPos,
    input  logic [9:0]           horCnt,
    input  logic [9:0]           verCnt,
    output logic [N_BULLETS-1:0] activeMask,
    output logic                 fired,
    output logic [5:0]           rgbContent
);
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int CW = (FIRE_GAP > 0) ? $clog2(FIRE_GAP + 1) : 1;

    logic [TW-1:0]        tickCnt;
    logic                 tick;
    logic                 fireQ, fireEvt, doAlloc;
    logic [CW-1:0]        cooldown;
    logic [N_BULLETS-1:0] allocSel, slotHit;

    assign tick = (tickCnt == TW'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tickCnt <= '0;
        else        tickCnt <= tick ? '0 : tickCnt + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fireQ <= 1'b0;
        else        fireQ <= fire;
    end

`ifdef BULLET_AUTOFIRE_EN
    assign fireEvt = fire;
`else
    assign fireEvt = fire & ~fireQ;
`endif

    // lowest-index free slot, from the mask as it stands at the start of the cycle
    always_comb begin
        allocSel = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!activeMask[i]) begin
                allocSel    = '0;
                allocSel[i] = 1'b1;
            end
        end
    end

    assign doAlloc = fireEvt && (cooldown == '0) && !(&activeMask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cooldown <= '0;
            fired    <= 1'b0;
        end else begin
            fired <= doAlloc;
            if (doAlloc)                      cooldown <= CW'(FIRE_GAP);
            else if (tick && cooldown != '0)  cooldown <= cooldown - CW'(1);
        end
    end

    for (genvar g = 0; g < N_BULLETS; g++) begin : gSlot
        bullet_slot #(
            .BULLET_LEN(BULLET_LEN),
            .BULLET_W  (BULLET_W),
            .SPAWN_Y   (SPAWN_Y)
        ) uSlot (
            .clk   (clk),
            .reset (reset),
            .alloc (doAlloc && allocSel[g]),
            .clr   (collision && collIdx == 3'(g)),
            .tick  (tick),
            .loadX (playerPos),
            .horCnt(horCnt),
            .verCnt(verCnt),
            .active(activeMask[g]),
            .hit   (slotHit[g])
        );
    end

    assign rgbContent = (|slotHit) ? 6'b111111 : 6'b000000;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: a per-cycle vector table plus retirement and reset sequences.
module tb_bullet_pool;
    logic       clk = 1'b0;
    logic       reset, fire, collision;
    logic [2:0] collIdx;
    logic [9:0] playerPos, horCnt, verCnt;
    logic [3:0] activeMask;
    logic       fired;
    logic [5:0] rgbContent;

    int nCmp = 0;
    int nBad = 0;
    int k    = 0;

    typedef struct {
        logic       fire;
        logic       coll;
        logic [2:0] idx;
        logic [9:0] pos;
        logic [9:0] hor;
        logic [9:0] ver;
        logic       expFired;
        logic [5:0] expRgb;
        logic [3:0] expMask;
    } vec_t;

    vec_t vec [1:48];

    bullet_pool #(
        .N_BULLETS (4),
        .BULLET_LEN(16),
        .BULLET_W  (1),
        .STEP_DIV  (4),
        .FIRE_GAP  (2),
        .SPAWN_Y   (10'd464)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fire      (fire),
        .collision (collision),
        .collIdx   (collIdx),
        .playerPos (playerPos),
        .horCnt    (horCnt),
        .verCnt    (verCnt),
        .activeMask(activeMask),
        .fired     (fired),
        .rgbContent(rgbContent)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    task automatic probe(input string nm, input int h, input int v, input int white);
        horCnt = 10'(h);
        verCnt = 10'(v);
        #1;
        chk(nm, 32'(rgbContent), (white != 0) ? 32'h3F : 32'h0);
    endtask

    task automatic setv(input int kk, input int f, input int c, input int ix, input int pos,
                        input int hor, input int ver, input int ef, input int er);
        vec[kk].fire     = (f != 0);
        vec[kk].coll     = (c != 0);
        vec[kk].idx      = 3'(ix);
        vec[kk].pos      = 10'(pos);
        vec[kk].hor      = 10'(hor);
        vec[kk].ver      = 10'(ver);
        vec[kk].expFired = (ef != 0);
        vec[kk].expRgb   = (er != 0) ? 6'h3F : 6'h00;
    endtask

    initial begin
        // ticks land on edges 4, 8, 12, ... after release; cooldown gap is 2 ticks
        for (int i = 1; i <= 48; i++) begin
            setv(i, 0, 0, 0, 0, 0, 0, 0, 0);
            if      (i <= 8)  vec[i].expMask = 4'b0001;
            else if (i <= 16) vec[i].expMask = 4'b0011;
            else if (i <= 24) vec[i].expMask = 4'b0111;
            else if (i <= 35) vec[i].expMask = 4'b1111;
            else if (i == 36) vec[i].expMask = 4'b1011;
            else if (i <= 45) vec[i].expMask = 4'b1111;
            else if (i <= 47) vec[i].expMask = 4'b1101;
            else              vec[i].expMask = 4'b1111;
        end
        setv( 1, 1, 0, 0, 100, 101, 464, 1, 1);
        setv( 2, 1, 0, 0,   0, 101, 479, 0, 1);
        setv( 3, 0, 1, 3,   0, 102, 470, 0, 0);
        setv( 4, 0, 0, 0,   0, 101, 479, 0, 0);
        setv( 5, 1, 0, 0,   0, 101, 463, 0, 1);
        setv( 6, 0, 0, 0,   0, 101, 478, 0, 1);
        setv( 8, 0, 0, 0,   0, 101, 462, 0, 1);
        setv( 9, 1, 0, 0, 200, 201, 464, 1, 1);
        setv(10, 0, 0, 0,   0, 101, 462, 0, 1);
        setv(11, 0, 0, 0,   0, 101, 461, 0, 0);
        setv(12, 0, 0, 0,   0, 101, 461, 0, 1);
        setv(16, 0, 0, 0,   0, 201, 477, 0, 1);
        setv(17, 1, 0, 0, 300, 301, 464, 1, 1);
        setv(25, 1, 0, 0, 400, 401, 479, 1, 1);
        setv(31, 0, 0, 0,   0, 401, 462, 0, 0);
        setv(32, 0, 0, 0,   0, 401, 462, 0, 1);
        setv(33, 1, 0, 0, 700, 701, 464, 0, 0);
        setv(35, 0, 0, 0,   0, 301, 460, 0, 1);
        setv(36, 0, 1, 2,   0, 301, 460, 0, 0);
        setv(37, 1, 0, 0, 500, 501, 464, 1, 1);
        setv(45, 0, 0, 0,   0, 201, 455, 0, 1);
        setv(46, 0, 1, 1,   0, 201, 455, 0, 0);
        setv(48, 1, 0, 0, 600, 601, 479, 1, 1);

        reset = 1'b0; fire = 1'b0; collision = 1'b0; collIdx = '0;
        playerPos = '0; horCnt = '0; verCnt = '0;
        step();
        step();
        chk("reset_mask", 32'(activeMask), 32'h0);
        chk("reset_fired", 32'(fired), 32'h0);
        chk("reset_rgb", 32'(rgbContent), 32'h0);
        reset = 1'b1;
        k = 0;

        for (int i = 1; i <= 48; i++) begin
            fire      = vec[i].fire;
            collision = vec[i].coll;
            collIdx   = vec[i].idx;
            playerPos = vec[i].pos;
            horCnt    = vec[i].hor;
            verCnt    = vec[i].ver;
            step();
            chk("vec_mask",  32'(activeMask), 32'(vec[i].expMask));
            chk("vec_fired", 32'(fired),      32'(vec[i].expFired));
            chk("vec_rgb",   32'(rgbContent), 32'(vec[i].expRgb));
        end

        // slot 0 reaches Y=0 at edge 1856 and retires on the tick at 1860
        fire = 1'b0; collision = 1'b0; collIdx = '0; playerPos = '0;
        while (k < 1856) step();
        chk("y0_mask", 32'(activeMask), 32'hF);
        probe("y0_top", 101, 0, 1);
        probe("y0_bot", 101, 15, 1);
        probe("y0_nowrap", 101, 1023, 0);
        while (k < 1860) step();
        chk("retire_mask", 32'(activeMask), 32'hE);
        probe("retire_rgb", 101, 0, 0);
        probe("retire_nowrap", 101, 1023, 0);
        probe("s1_top", 601, 11, 1);
        probe("s1_bot", 601, 26, 1);
        probe("s1_below", 601, 27, 0);

        // asynchronous reset with three bullets in flight, between clock edges
        horCnt = 10'd601; verCnt = 10'd11;
        reset  = 1'b0;
        #1;
        chk("async_mask", 32'(activeMask), 32'h0);
        chk("async_rgb", 32'(rgbContent), 32'h0);
        chk("async_fired", 32'(fired), 32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        fire = 1'b1; playerPos = 10'd50; horCnt = 10'd51; verCnt = 10'd464;
        step();
        chk("post_reset_fired", 32'(fired), 32'h1);
        chk("post_reset_mask", 32'(activeMask), 32'h1);
        chk("post_reset_rgb", 32'(rgbContent), 32'h3F);
        step();
        chk("post_reset_pulse", 32'(fired), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
